atan2_arbiter: RTL and testbench

Round-robin arbiter that shares one pipelined `atan2` instance between `CHANNELS` independent requesters. Each requester offers a (y, x) operand pair through a valid/ready handshake. The arbiter issues at most one pair per clock into the `atan2` pipeline and tags every issued pair with its channel index. When the result emerges `DELAY` cycles later, it is returned on a shared response bus that carries the channel tag. The block sits between the phase-measurement front ends and the single `atan2` datapath instance.

---
 rtl/atan2_arbiter.sv | 113 +++++++++++
 tb/tb_atan2_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/atan2_arbiter.sv
// atan2_arbiter: round-robin issue of (y, x) pairs from several channels into
// one fixed-latency atan2 pipeline, with a tag pipeline that routes each result
// back to its channel.
module atan2_arbiter #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DELAY    = 8,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned CW      = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       req_valid,
  output logic [CHANNELS-1:0]       req_ready,
  input  logic [CHANNELS*WIDTH-1:0] req_y,
  input  logic [CHANNELS*WIDTH-1:0] req_x,
  output logic [WIDTH-1:0]          atan_y,
  output logic [WIDTH-1:0]          atan_x,
  input  logic [15:0]               atan_result,
  output logic                      rsp_valid,
  output logic [CW-1:0]             rsp_chan,
  output logic [15:0]               rsp_data,
  output logic                      busy
);

  logic [CW-1:0]       r_ptr;
  logic [WIDTH-1:0]    r_atan_y;
  logic [WIDTH-1:0]    r_atan_x;
  logic [DELAY:0]      r_tag_v;
  logic [CW-1:0]       r_tag_c [DELAY+1];
  logic                r_rsp_valid;
  logic [CW-1:0]       r_rsp_chan;
  logic [15:0]         r_rsp_data;

  logic [CHANNELS-1:0] w_grant;
  logic [CW-1:0]       w_gidx;
  logic                w_found;
  logic                w_fire;
  logic [CW-1:0]       w_ptr_nxt;
  logic [WIDTH-1:0]    w_y;
  logic [WIDTH-1:0]    w_x;

  // First valid channel at or after ptr, wrapping; nothing granted in reset.
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (!w_found && req_valid[CW'((32'(r_ptr) + i) % CHANNELS)]) begin
        w_found = 1'b1;
        w_gidx  = CW'((32'(r_ptr) + i) % CHANNELS);
      end
    end
    if (w_found && !reset) begin
      w_grant[w_gidx] = 1'b1;
    end
  end

  assign w_fire    = |w_grant;
  assign w_ptr_nxt = CW'((32'(w_gidx) + 32'd1) % CHANNELS);

  // Operand mux for the granted channel.
  always_comb begin
    w_y = '0;
    w_x = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (w_grant[c]) begin
        w_y = req_y[c*WIDTH +: WIDTH];
        w_x = req_x[c*WIDTH +: WIDTH];
      end
    end
  end

  // Issue register, tag shift pipeline and response capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr       <= '0;
      r_atan_y    <= '0;
      r_atan_x    <= '0;
      r_tag_v     <= '0;
      for (int unsigned k = 0; k <= DELAY; k++) begin
        r_tag_c[k] <= '0;
      end
      r_rsp_valid <= 1'b0;
      r_rsp_chan  <= '0;
      r_rsp_data  <= '0;
    end else begin
      if (w_fire) begin
        r_ptr    <= w_ptr_nxt;
        r_atan_y <= w_y;
        r_atan_x <= w_x;
      end
      r_tag_v    <= {r_tag_v[DELAY-1:0], w_fire};
      r_tag_c[0] <= w_gidx;
      for (int unsigned k = 1; k <= DELAY; k++) begin
        r_tag_c[k] <= r_tag_c[k-1];
      end
      r_rsp_valid <= r_tag_v[DELAY];
      r_rsp_chan  <= r_tag_c[DELAY];
      if (r_tag_v[DELAY]) begin
        r_rsp_data <= atan_result;
      end
    end
  end

  assign req_ready = w_grant;
  assign atan_y    = r_atan_y;
  assign atan_x    = r_atan_x;
  assign rsp_valid = r_rsp_valid;
  assign rsp_chan  = r_rsp_chan;
  assign rsp_data  = r_rsp_data;
  assign busy      = (|r_tag_v) | r_rsp_valid;

endmodule

// File: tb/tb_atan2_arbiter.sv
// Directed bench for atan2_arbiter with a fixed-latency stand-in for atan2.
module tb_atan2_arbiter;
  localparam int W  = 16;
  localparam int D  = 8;
  localparam int C  = 4;
  localparam int CW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [C-1:0]   req_valid;
  logic [C-1:0]   req_ready;
  logic [C*W-1:0] req_y;
  logic [C*W-1:0] req_x;
  logic [W-1:0]   atan_y;
  logic [W-1:0]   atan_x;
  logic [15:0]    atan_result;
  logic           rsp_valid;
  logic [CW-1:0]  rsp_chan;
  logic [15:0]    rsp_data;
  logic           busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  atan2_arbiter #(.WIDTH(W), .DELAY(D), .CHANNELS(C)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_y(req_y), .req_x(req_x),
    .atan_y(atan_y), .atan_x(atan_x), .atan_result(atan_result),
    .rsp_valid(rsp_valid), .rsp_chan(rsp_chan), .rsp_data(rsp_data),
    .busy(busy)
  );

  // Stand-in atan2: exact on the diagonal and the axes, y+x elsewhere.
  function automatic logic [15:0] fake_atan(input logic signed [15:0] y, input logic signed [15:0] x);
    if (x > 0 && y == x) return 16'h1922;
    else if (y == 0 && x > 0) return 16'h0000;
    else if (x == 0 && y > 0) return 16'h3244;
    else return 16'(y + x);
  endfunction

  logic [15:0] stub_pipe [D];
  always @(posedge clk) begin
    stub_pipe[0] <= fake_atan(atan_y, atan_x);
    for (int k = 1; k < D; k++) stub_pipe[k] <= stub_pipe[k-1];
  end
  assign atan_result = stub_pipe[D-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int c, input logic [15:0] y, input logic [15:0] x);
    req_y[c*W +: W] = y;
    req_x[c*W +: W] = x;
  endtask

  task automatic load_full(input int g);
    for (int c = 0; c < C; c++) set_ops(c, 16'(16'h0100 * (c + 1) + g), 16'(16'h3000 + g));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int hit_k;
    int stray;
    reset     = 1'b1;
    req_valid = '0;
    req_y     = '0;
    req_x     = '0;

    // Reset state
    tick(); tick();
    req_valid = '1;
    #1;
    chk("ready_in_reset", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_chan", 32'(rsp_chan), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_atan_y", 32'(atan_y), 32'h0);
    chk("rst_atan_x", 32'(atan_x), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    req_valid = '0;
    tick();
    reset = 1'b0;

    // Single transfer on ch1, diagonal operands
    set_ops(1, 16'd1000, 16'd1000);
    req_valid = 4'b0010;
    #1;
    chk("single_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    chk("single_atan_y", 32'(atan_y), 32'd1000);
    chk("single_atan_x", 32'(atan_x), 32'd1000);
    chk("single_busy0", 32'(busy), 32'h1);
    chk("single_rv0", 32'(rsp_valid), 32'h0);
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk("single_rv", 32'(rsp_valid), 32'(k == 9));
      chk("single_busy", 32'(busy), 32'(k <= 9));
      if (k == 9) begin
        chk("single_chan", 32'(rsp_chan), 32'h1);
        chk("single_data", 32'(rsp_data), 32'h1922);
      end
    end

    // Axis cases: ch2 then ch3 (ptr is 2 here)
    set_ops(2, 16'd0, 16'd500);
    set_ops(3, 16'd700, 16'd0);
    req_valid = 4'b0100;
    #1;
    chk("axis_ready2", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b1000;
    #1;
    chk("axis_ready3", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    for (int k = 2; k <= 11; k++) begin
      tick();
      chk("axis_rv", 32'(rsp_valid), 32'(k == 9 || k == 10));
      if (k == 9) begin
        chk("axis_chan_a", 32'(rsp_chan), 32'h2);
        chk("axis_data_a", 32'(rsp_data), 32'h0000);
      end
      if (k == 10) begin
        chk("axis_chan_b", 32'(rsp_chan), 32'h3);
        chk("axis_data_b", 32'(rsp_data), 32'h3244);
      end
    end
    chk("axis_busy_end", 32'(busy), 32'h0);

    // Full load, ptr back at 0 after the ch3 wrap
    load_full(0);
    req_valid = '1;
    #1;
    chk("full_ready0", 32'(req_ready), 32'h1);
    for (int k = 0; k <= 26; k++) begin
      tick();
      if (k < 15) begin
        load_full(k + 1);
        #1;
        chk("full_ready", 32'(req_ready), 32'(1 << ((k + 1) % 4)));
      end else if (k == 15) begin
        req_valid = '0;
      end
      chk("full_rv", 32'(rsp_valid), 32'(k >= 9 && k <= 24));
      if (k >= 9 && k <= 24) begin
        chk("full_chan", 32'(rsp_chan), 32'((k - 9) % 4));
        chk("full_data", 32'(rsp_data), 32'(16'h3000 + 16'h0100 * ((k - 9) % 4 + 1) + 2 * (k - 9)));
      end
    end
    chk("full_busy_end", 32'(busy), 32'h0);

    // Withdrawal before any edge has no effect
    req_valid = 4'b0100;
    #1;
    req_valid = '0;
    tick();
    chk("withdraw_busy", 32'(busy), 32'h0);

    // Lone requester granted every cycle, leaving ptr at 1
    req_valid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("lone_ready", 32'(req_ready), 32'h1);
      tick();
    end

    // Round-robin skip: ptr=1, only ch0 and ch3 valid
    req_valid = 4'b1001;
    #1;
    chk("skip_first", 32'(req_ready), 32'h8);
    tick();
    #1;
    chk("skip_second", 32'(req_ready), 32'h1);
    tick();
    #1;
    chk("skip_third", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    repeat (12) tick();
    chk("skip_busy_end", 32'(busy), 32'h0);

    // Reset after the 3rd response of an 8-transfer burst
    load_full(0);
    req_valid = '1;
    cnt   = 0;
    hit_k = -1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (k == 7) req_valid = '0;
      if (rsp_valid) cnt++;
      if (cnt == 3) begin
        hit_k = k;
        break;
      end
    end
    chk("midrst_third_at", 32'(hit_k), 32'd11);
    reset     = 1'b1;
    req_valid = '1;
    #1;
    chk("midrst_ready_forced", 32'(req_ready), 32'h0);
    tick();
    reset     = 1'b0;
    req_valid = '0;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_rv", 32'(rsp_valid), 32'h0);
    chk("midrst_atan_y", 32'(atan_y), 32'h0);
    stray = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (rsp_valid || busy) stray++;
    end
    chk("midrst_stray", 32'(stray), 32'h0);

    // First transfer after reset: ptr is 0 again
    set_ops(0, 16'd5, 16'd5);
    req_valid = '1;
    #1;
    chk("postrst_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("postrst_rv", 32'(rsp_valid), 32'(k == 9));
      if (k == 9) begin
        chk("postrst_chan", 32'(rsp_chan), 32'h0);
        chk("postrst_data", 32'(rsp_data), 32'h1922);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
